// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared deck constants, FSM states and index-to-card mapping
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int NRANK     = 13;
    localparam int NSUIT     = 4;
    localparam int NUM_W     = 4;
    localparam int SUIT_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DEAL,
        DONE
    } state_t;

    typedef struct packed {
        logic [NUM_W-1:0]  rank;
        logic [SUIT_W-1:0] suit;
    } card_t;

    // Compare chain instead of a divider: c/13 selects the suit, the remainder gives the rank.
    // Only meaningful for c < DECK_SIZE; callers reject larger indices first.
    function automatic card_t idx_to_card(input logic [5:0] c);
        card_t r;
        if (c < 6'd13) begin
            r.suit = 3'd0;
            r.rank = 4'(c + 6'd1);
        end else if (c < 6'd26) begin
            r.suit = 3'd1;
            r.rank = 4'(c - 6'd12);
        end else if (c < 6'd39) begin
            r.suit = 3'd2;
            r.rank = 4'(c - 6'd25);
        end else begin
            r.suit = 3'd3;
            r.rank = 4'(c - 6'd38);
        end
        return r;
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// rtl/card_dealer_if.sv - deal request/response bundle between game FSM and dealer
interface card_dealer_if
    import card_pkg::*;
#(
    parameter int NCARD = 12
);
    logic                      deal_req;
    logic                      busy;
    logic                      deal_done;
    logic [NUM_W*NCARD-1:0]    num_o;
    logic [SUIT_W*NCARD-1:0]   suit_o;

    modport master (
        output deal_req,
        input  busy,
        input  deal_done,
        input  num_o,
        input  suit_o
    );

    modport slave (
        input  deal_req,
        output busy,
        output deal_done,
        output num_o,
        output suit_o
    );
endinterface

// File: rtl/card_dealer_lfsr16.sv
// rtl/card_dealer_lfsr16.sv - free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        xreset,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // Shift every cycle regardless of the dealer state; a non-zero seed keeps it off the all-zero lockup.
    always_ff @(posedge clock or negedge xreset) begin
        if (!xreset) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[14:0], r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals NCARD distinct cards by rejection sampling an LFSR
module card_dealer
    import card_pkg::*;
#(
    parameter int          NCARD = 12,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic        clock,
    input  logic        xreset,
    card_dealer_if.slave bus
);

    localparam int            KW   = (NCARD > 1) ? $clog2(NCARD) : 1;
    localparam logic [KW-1:0] LAST = KW'(NCARD - 1);

    logic [15:0]          w_lfsr;
    logic [5:0]           w_c;
    logic                 w_accept;
    logic                 w_unused;
    card_t                w_card;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [DECK_SIZE-1:0] r_used;
    logic [KW-1:0]        r_k;
    logic [NUM_W-1:0]     r_num  [NCARD];
    logic [SUIT_W-1:0]    r_suit [NCARD];

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clock  (clock),
        .xreset (xreset),
        .q      (w_lfsr)
    );

    // Only the low six bits form the candidate; the rest just feed the shift register.
    assign w_c      = w_lfsr[5:0];
    assign w_unused = ^w_lfsr[15:6];
    assign w_card   = idx_to_card(w_c);
    assign w_accept = (w_c < 6'(DECK_SIZE)) && !r_used[w_c];

    // Deal sequencer: clear, fill one slot per accepted candidate, then pulse done.
    always_ff @(posedge clock or negedge xreset) begin
        if (!xreset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_used  <= '0;
            r_k     <= '0;
            for (int i = 0; i < NCARD; i++) begin
                r_num[i]  <= '0;
                r_suit[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.deal_req) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_used <= '0;
                    r_k    <= '0;
                    for (int i = 0; i < NCARD; i++) begin
                        r_num[i]  <= '0;
                        r_suit[i] <= '0;
                    end
                    r_state <= DEAL;
                end
                DEAL: begin
                    if (w_accept) begin
                        r_num[r_k]    <= w_card.rank;
                        r_suit[r_k]   <= w_card.suit;
                        r_used[w_c]   <= 1'b1;
                        r_k           <= r_k + KW'(1);
                        if (r_k == LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.deal_done = r_done;

    for (genvar g = 0; g < NCARD; g++) begin : g_out
        assign bus.num_o[NUM_W*g +: NUM_W]    = r_num[g];
        assign bus.suit_o[SUIT_W*g +: SUIT_W] = r_suit[g];
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Upstream of the draw and double-up stages. Deals NCARD distinct cards from one 52-card deck, with no duplicates within a deal.
- Cards come from a free-running LFSR using rejection sampling: an index is discarded if it is out of range or already used.
- A one-cycle deal_req, taken from the game FSM at game start, starts a fresh shuffle. The block returns a deal_done pulse once every slot is filled.
- Slots 0-4 are the initial hand, 5-9 the replacement cards, and the remaining slots the double-up cards.

Parameters:
- NCARD, 12, cards dealt per request (1..52). 10 are for poker, 2 are for double-up.
- SEED, 16'hACE1, LFSR reset value. Must be non-zero.

Ports:
- clock  in  1  system clock
- xreset  in  1  asynchronous active-low reset
- deal_req  in  1  one-cycle start pulse, already debounced/oneshot upstream
- busy  out  1  high from acceptance of deal_req until deal_done
- deal_done  out  1  one-cycle pulse when all NCARD slots are valid
- num_o  out  4*NCARD  slot k is at [4k+3:4k]; rank 1..13 (1=A, 11=J, 12=Q, 13=K)
- suit_o  out  3*NCARD  slot k is at [3k+2:3k]; suit 0..3, bit 2 always 0

Behaviour:
- Reset (xreset=0, async):
  - state IDLE; busy=0; deal_done=0
  - num_o=0; suit_o=0
  - used mask (52 bits)=0; slot counter k=0; lfsr=SEED
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every clock in every state, so entropy comes from player timing.
  - Never zero.
- Candidate index: c = lfsr[5:0].
- States:
  - IDLE:
    - deal_req=1 -> CLEAR; busy=1 on the next edge.
    - deal_req=0 -> stay.
  - CLEAR (1 cycle):
    - used mask=0; k=0; num_o/suit_o=0.
    - -> DEAL.
  - DEAL (one candidate evaluated per cycle):
    - If c<52 and used[c]=0: slot k <= {rank = c%13+1, suit = c/13}; used[c] <= 1; k <= k+1.
    - Otherwise reject: no state change, retry next cycle.
    - When the card accepted is the one with k=NCARD-1 -> DONE.
  - DONE (1 cycle):
    - deal_done=1; busy=0 on the next edge.
    - -> IDLE.
- Latency:
  - deal_req at edge 0 -> deal_done high in cycle NCARD+2 at the earliest, when there are no rejections.
  - Worst case is bounded: in a maximal-length LFSR every 6-bit low value recurs within 65535 cycles.
- Outputs:
  - Slots are written as they are dealt. Consumers use them only after deal_done.
  - Outputs hold until the next CLEAR.
- Boundary and simultaneous-event rules:
  - deal_req while busy=1: ignored, not queued.
  - deal_req in the same cycle as deal_done: ignored, because the state is still DONE.
  - Rank/suit division (c%13, c/13): by a 52-entry constant mapping or compare chain. No divider.
  - Reset mid-deal: immediate return to the reset values. A partial deal is discarded and deal_done never fires.
  - NCARD=52: the last cards may need many retries. The design must still terminate.

Decomposition:
- Shared package card_pkg:
  - constants DECK_SIZE=52, NRANK=13, NSUIT=4, NUM_W=4, SUIT_W=3
  - state enum IDLE/CLEAR/DEAL/DONE
  - function idx_to_card(c) returning {rank, suit}
- Sub-module lfsr16: clock, xreset, SEED parameter, q[15:0]. It is shared later by the double-up shuffle.

Test Plan:
- Reset with SEED=16'hACE1: num_o=0, suit_o=0, busy=0, deal_done=0. Release xreset, then pulse deal_req at cycle 5.
  - busy=1 from cycle 6.
  - deal_done is a single pulse.
  - All 12 slots have rank in 1..13 and suit in 0..3.
  - The 12 {rank,suit} pairs are pairwise distinct.
  - Values match a C/SV reference model of the same LFSR, cycle-exact.
- Back-to-back: 1000 deals, each deal_req issued 3 cycles after the previous deal_done.
  - There are never duplicates within a deal.
  - Every one of the 52 cards appears at least once across the run.
- Pulse deal_req again at DEAL k=4 and in the DONE cycle.
  - The deal is not restarted.
  - deal_done count equals 1.
  - Slots 0-3 are unchanged.
- Assert xreset=0 while k=7: all outputs return to 0 asynchronously within the same cycle, with no deal_done. The next deal_req deals a full 12 cards.
- Force the LFSR (bind/force) to yield c=52..63, then c=0, then c=0 again.
  - 52..63 are rejected.
  - c=0 gives rank 1, suit 0.
  - The repeated 0 is rejected.
  - Then c=51 gives rank 13, suit 3, and c=13 gives rank 1, suit 1.
- Minimum-latency case, all candidates accepted: deal_req at edge 0 -> deal_done at cycle 14 (NCARD+2); busy is low at cycle 15.
